// File: rtl/bf_loop_ctrl.sv
// bf_loop_ctrl
//   Loop controller for a brainfuck sequencer, acting as the initiator on the
//   push/pop interface of an attached stack2.  It executes '[' and ']':
//   pushes loop-return addresses, pops when a loop exits, issues backward
//   jumps, and runs the forward-skip scan using a nesting counter.  stack2
//   has no full/empty flags, so the stack depth is tracked here.
//
// Ports
//   clk        rising-edge clock
//   resetq     asynchronous reset, active low
//   ins_valid  sequencer presents an instruction
//   ins_ready  instruction accepted when ins_valid & ins_ready
//   ins_code   00 other, 01 '[', 10 ']', 11 other
//   ins_pc     address of the presented instruction
//   cell_zero  current data cell is zero (qualified by ins_valid)
//   skipping   high during the forward-skip scan
//   jmp        one-cycle pulse: sequencer loads PC from jmp_pc
//   jmp_pc     jump target, valid while jmp is high
//   err        sticky stack overflow/underflow or nest overflow
//   stk_we     stack2 write enable
//   stk_delta  stack2 pointer delta (01 push, 11 pop, 00 hold)
//   stk_wd     stack2 write data
//   stk_rd     stack2 top of stack
module bf_loop_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          resetq,
   input  logic          ins_valid,
   output logic          ins_ready,
   input  logic [1:0]    ins_code,
   input  logic [AW-1:0] ins_pc,
   input  logic          cell_zero,
   output logic          skipping,
   output logic          jmp,
   output logic [AW-1:0] jmp_pc,
   output logic          err,
   output logic          stk_we,
   output logic [1:0]    stk_delta,
   output logic [AW-1:0] stk_wd,
   input  logic [AW-1:0] stk_rd
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
   localparam logic [AW-1:0] NEST_MAX  = '1;

   localparam logic [1:0] CODE_OPEN  = 2'b01;
   localparam logic [1:0] CODE_CLOSE = 2'b10;

   localparam logic [1:0] DELTA_HOLD = 2'b00;
   localparam logic [1:0] DELTA_PUSH = 2'b01;
   localparam logic [1:0] DELTA_POP  = 2'b11;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_SKIP = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] depth_q, depth_d;
   logic [AW-1:0] nest_q,  nest_d;
   logic          jmp_q,   jmp_d;
   logic [AW-1:0] jmp_pc_q, jmp_pc_d;
   logic          acc;

   // While a jump pulse is out the sequencer is reloading its PC, so the
   // instruction it currently presents is stale and must not be taken.
   assign ins_ready = (state_q != S_ERR) & ~jmp_q;
   assign acc       = ins_valid & ins_ready;

   assign skipping  = (state_q == S_SKIP);
   assign err       = (state_q == S_ERR);
   assign jmp       = jmp_q;
   assign jmp_pc    = jmp_pc_q;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q  <= S_RUN;
         depth_q  <= '0;
         nest_q   <= '0;
         jmp_q    <= 1'b0;
         jmp_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         nest_q   <= nest_d;
         jmp_q    <= jmp_d;
         jmp_pc_q <= jmp_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      nest_d    = nest_q;
      jmp_d     = 1'b0;
      jmp_pc_d  = jmp_pc_q;
      stk_we    = 1'b0;
      stk_delta = DELTA_HOLD;
      stk_wd    = '0;

      unique case (state_q)
         S_RUN: begin
            if (acc) begin
               if (ins_code == CODE_OPEN) begin
                  if (!cell_zero) begin
                     // Bounds are checked before the stack op, so depth
                     // never wraps.
                     if (depth_q < DEPTH_MAX) begin
                        stk_we    = 1'b1;
                        stk_delta = DELTA_PUSH;
                        stk_wd    = ins_pc + AW'(1);
                        depth_d   = depth_q + DW'(1);
                     end else begin
                        state_d = S_ERR;
                     end
                  end else begin
                     nest_d  = AW'(1);
                     state_d = S_SKIP;
                  end
               end else if (ins_code == CODE_CLOSE) begin
                  if (depth_q == '0) begin
                     state_d = S_ERR;
                  end else if (!cell_zero) begin
                     // Jump back to the body start; the entry stays on the
                     // stack for the next iteration.
                     jmp_d    = 1'b1;
                     jmp_pc_d = stk_rd;
                  end else begin
                     stk_delta = DELTA_POP;
                     depth_d   = depth_q - DW'(1);
                  end
               end
            end
         end

         S_SKIP: begin
            if (acc) begin
               if (ins_code == CODE_OPEN) begin
                  if (nest_q == NEST_MAX) begin
                     state_d = S_ERR;
                  end else begin
                     nest_d = nest_q + AW'(1);
                  end
               end else if (ins_code == CODE_CLOSE) begin
                  if (nest_q == AW'(1)) begin
                     nest_d  = '0;
                     state_d = S_RUN;
                  end else begin
                     nest_d = nest_q - AW'(1);
                  end
               end
            end
         end

         S_ERR: begin
            state_d = S_ERR;
         end

         default: begin
            state_d = S_ERR;
         end
      endcase
   end

endmodule
